// File: rtl/imem_loadable.sv
// imem_loadable: runtime-loadable instruction memory for the MIPS datapath.
//
// After reset the block walks every word and writes a NOP (all-zero) word
// into it, then raises ready.  From then on it serves one registered fetch
// and accepts one load per cycle.  A load and a fetch of the same word in
// the same cycle are write-first: the fetch returns the word being loaded.
//
// Optional feature (macro IMEM_PARITY_EN):
//   defined   - each word carries an even-parity bit; fetches recompute it
//               and flag a mismatch on parity_err.  load_par_inv inverts
//               the stored bit so the check can be exercised.
//   undefined - no parity storage; load_par_inv ignored; parity_err = 0.
//
// Ports:
//   clk           clock, all state changes on the rising edge
//   reset         synchronous active-high reset
//   fetch_en      fetch request this cycle
//   fetch_addr    word address to fetch
//   fetch_data    fetched word, registered
//   fetch_valid   fetch_data was updated by a request last cycle
//   load_en       write request this cycle
//   load_addr     word address to write
//   load_data     word to write
//   load_par_inv  invert the stored parity bit of this write
//   ready         clear finished; fetch and load accepted
//   load_err      one-cycle pulse: the load of last cycle was rejected
//   parity_err    qualifies fetch_valid: fetched word failed parity check
//
// States:
//   CLEAR | writing zero to word[ptr], ptr counts 0..DEPTH-1
//   RUN   | normal operation until next reset
module imem_loadable #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_en,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [DATA_W-1:0] fetch_data,
    output logic              fetch_valid,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_par_inv,
    output logic              ready,
    output logic              load_err,
    output logic              parity_err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0] PTR_LAST = IDX_W'(DEPTH - 1);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t            state;
    state_t            state_next;
    logic [IDX_W-1:0]  ptr;
    logic [DATA_W-1:0] mem [0:DEPTH-1];

    logic              fetch_in;
    logic              load_in;
    logic              clr_we;
    logic              load_we;
    logic              hit;
    logic [IDX_W-1:0]  wr_idx;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_word;
    logic              perr_calc;

    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= CLEAR;
        else       state <= state_next;
    end

    // next-state logic
    always_comb begin
        state_next = state;
        if (state == CLEAR && ptr == PTR_LAST) state_next = RUN;
    end

    // output / datapath control
    always_comb begin
        fetch_in = {1'b0, fetch_addr} < DEPTH_LIM;
        load_in  = {1'b0, load_addr} < DEPTH_LIM;
        clr_we   = (state == CLEAR);
        // ready (not state) gates requests, so nothing is accepted until
        // the cycle after the last word has been cleared.
        load_we  = ready && load_en && load_in;
        hit      = load_we && (fetch_addr == load_addr);
        wr_idx   = clr_we ? ptr : load_addr[IDX_W-1:0];
        wr_data  = clr_we ? '0 : load_data;
        rd_word  = hit ? load_data : mem[fetch_addr[IDX_W-1:0]];
    end

    always_ff @(posedge clk) begin
        if (reset)               ptr <= '0;
        else if (state == CLEAR) ptr <= ptr + 1'b1;
    end

    // Storage has no reset; the clear sequence initialises it.  Reset still
    // blocks writes so the reset cycle never alters memory.
    always_ff @(posedge clk) begin
        if (!reset && (clr_we || load_we)) mem[wr_idx] <= wr_data;
    end

`ifdef IMEM_PARITY_EN
    logic par_mem [0:DEPTH-1];
    logic wr_par;
    logic rd_par;

    always_comb begin
        wr_par    = clr_we ? 1'b0 : ((^load_data) ^ load_par_inv);
        rd_par    = hit ? ((^load_data) ^ load_par_inv)
                        : par_mem[fetch_addr[IDX_W-1:0]];
        perr_calc = (^rd_word) != rd_par;
    end

    always_ff @(posedge clk) begin
        if (!reset && (clr_we || load_we)) par_mem[wr_idx] <= wr_par;
    end
`else
    logic unused_par_inv;
    assign unused_par_inv = load_par_inv;
    assign perr_calc      = 1'b0;
`endif

    // registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_data  <= '0;
            fetch_valid <= 1'b0;
            ready       <= 1'b0;
            load_err    <= 1'b0;
            parity_err  <= 1'b0;
        end else begin
            ready    <= (state == RUN);
            load_err <= load_en && !(ready && load_in);
            if (ready && fetch_en) begin
                fetch_valid <= 1'b1;
                if (fetch_in) begin
                    fetch_data <= rd_word;
                    parity_err <= perr_calc;
                end else begin
                    fetch_data <= '0;
                    parity_err <= 1'b0;
                end
            end else begin
                fetch_valid <= 1'b0;
                parity_err  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_imem_loadable.sv
// Testbench for imem_loadable (DEPTH=16): reset/clear timing, table-driven
// fetch/load vectors, and a reset-mid-run sequence.  Parity expectations
// follow IMEM_PARITY_EN.
module tb_imem_loadable;

    localparam int AW  = 8;
    localparam int DW  = 16;
    localparam int DEP = 16;
`ifdef IMEM_PARITY_EN
    localparam bit PEN = 1'b1;
`else
    localparam bit PEN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          fetch_en;
    logic [AW-1:0] fetch_addr;
    logic [DW-1:0] fetch_data;
    logic          fetch_valid;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [DW-1:0] load_data;
    logic          load_par_inv;
    logic          ready;
    logic          load_err;
    logic          parity_err;

    int total = 0;
    int bad   = 0;

    imem_loadable #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEP)) dut (
        .clk         (clk),
        .reset       (reset),
        .fetch_en    (fetch_en),
        .fetch_addr  (fetch_addr),
        .fetch_data  (fetch_data),
        .fetch_valid (fetch_valid),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .load_par_inv(load_par_inv),
        .ready       (ready),
        .load_err    (load_err),
        .parity_err  (parity_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          fe;
        logic [AW-1:0] fa;
        logic          le;
        logic [AW-1:0] la;
        logic [DW-1:0] ld;
        logic          pi;
        logic          ev;
        logic [DW-1:0] ed;
        logic          ele;
        logic          epe;  // parity error expected when parity is built
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic fe, input logic [AW-1:0] fa,
                               input logic le, input logic [AW-1:0] la,
                               input logic [DW-1:0] ld, input logic pi,
                               input logic ev, input logic [DW-1:0] ed,
                               input logic ele, input logic epe);
        vec_t r;
        r.fe = fe; r.fa = fa; r.le = le; r.la = la; r.ld = ld; r.pi = pi;
        r.ev = ev; r.ed = ed; r.ele = ele; r.epe = epe;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic fe, input logic [AW-1:0] fa, input logic le,
                         input logic [AW-1:0] la, input logic [DW-1:0] ld, input logic pi);
        fetch_en = fe; fetch_addr = fa;
        load_en = le; load_addr = la; load_data = ld; load_par_inv = pi;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        // reset held two cycles, with requests that must be ignored
        reset = 1'b1;
        drive(1, 8'd2, 1, 8'd2, 16'hAAAA, 0);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("rst_ready", ready, 0);
            chk("rst_valid", fetch_valid, 0);
            chk("rst_data", fetch_data, 0);
            chk("rst_lerr", load_err, 0);
            chk("rst_perr", parity_err, 0);
        end

        // clear phase: ready after 16 clear cycles plus one; fetch ignored;
        // a late load to an already-cleared word must be rejected
        reset = 1'b0;
        for (int i = 0; i <= DEP; i++) begin
            drive(1, 8'd2, (i == DEP - 1), 8'd2, 16'hBEEF, 0);
            step();
            chk("clr_ready", ready, (i == DEP));
            chk("clr_valid", fetch_valid, 0);
            chk("clr_lerr", load_err, (i == DEP - 1));
        end

        for (int a = 0; a < DEP; a++)
            tbl.push_back(v(1, AW'(a), 0, 0, 0, 0, 1, 16'h0000, 0, 0));
        tbl.push_back(v(0, 0,     1, 8'd1,  16'h4806, 0, 0, 16'h0000, 0, 0));
        tbl.push_back(v(0, 0,     1, 8'd2,  16'h4A04, 0, 0, 16'h0000, 0, 0));
        tbl.push_back(v(1, 8'd2,  0, 0,     0,        0, 1, 16'h4A04, 0, 0));
        tbl.push_back(v(1, 8'd1,  0, 0,     0,        0, 1, 16'h4806, 0, 0));
        tbl.push_back(v(0, 0,     0, 0,     0,        0, 0, 16'h4806, 0, 0));
        tbl.push_back(v(1, 8'h0A, 1, 8'h0A, 16'h8850, 0, 1, 16'h8850, 0, 0));
        tbl.push_back(v(1, 8'd1,  1, 8'd5,  16'h1234, 0, 1, 16'h4806, 0, 0));
        tbl.push_back(v(1, 8'd5,  0, 0,     0,        0, 1, 16'h1234, 0, 0));
        tbl.push_back(v(0, 0,     1, 8'h20, 16'h5555, 0, 0, 16'h1234, 1, 0));
        tbl.push_back(v(1, 8'h20, 0, 0,     0,        0, 1, 16'h0000, 0, 0));
        tbl.push_back(v(1, 8'h10, 1, 8'h10, 16'h2222, 0, 1, 16'h0000, 1, 0));
        tbl.push_back(v(1, 8'h0F, 1, 8'h0F, 16'hFFFF, 0, 1, 16'hFFFF, 0, 0));
        tbl.push_back(v(1, 8'h0F, 0, 0,     0,        0, 1, 16'hFFFF, 0, 0));
        tbl.push_back(v(0, 0,     1, 8'd4,  16'h6080, 1, 0, 16'hFFFF, 0, 0));
        tbl.push_back(v(1, 8'd4,  0, 0,     0,        0, 1, 16'h6080, 0, 1));
        tbl.push_back(v(1, 8'd4,  1, 8'd4,  16'h6080, 0, 1, 16'h6080, 0, 0));
        tbl.push_back(v(1, 8'd4,  0, 0,     0,        0, 1, 16'h6080, 0, 0));
        tbl.push_back(v(1, 8'd6,  1, 8'd6,  16'h0001, 1, 1, 16'h0001, 0, 1));
        tbl.push_back(v(1, 8'hFF, 0, 0,     0,        0, 1, 16'h0000, 0, 0));
        tbl.push_back(v(0, 0,     1, 8'd3,  16'h3D00, 0, 0, 16'h0000, 0, 0));
        tbl.push_back(v(1, 8'd3,  0, 0,     0,        0, 1, 16'h3D00, 0, 0));

        foreach (tbl[k]) begin
            drive(tbl[k].fe, tbl[k].fa, tbl[k].le, tbl[k].la, tbl[k].ld, tbl[k].pi);
            step();
            chk($sformatf("vec%0d_valid", k), fetch_valid, tbl[k].ev);
            chk($sformatf("vec%0d_data", k), fetch_data, tbl[k].ed);
            chk($sformatf("vec%0d_lerr", k), load_err, tbl[k].ele);
            chk($sformatf("vec%0d_perr", k), parity_err, tbl[k].epe & PEN);
            chk($sformatf("vec%0d_ready", k), ready, 1);
        end

        // reset mid-run: the reset cycle's load and fetch are dropped
        reset = 1'b1;
        drive(1, 8'd3, 1, 8'd7, 16'h7777, 0);
        step();
        chk("mid_rst_ready", ready, 0);
        chk("mid_rst_valid", fetch_valid, 0);
        chk("mid_rst_data", fetch_data, 0);
        chk("mid_rst_lerr", load_err, 0);

        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        n = 0;
        while (!ready && n < 40) begin
            step();
            n++;
        end
        chk("mid_ready_seen", ready, 1);
        chk("mid_clear_len", n, DEP + 1);

        drive(1, 8'd3, 0, 0, 0, 0);
        step();
        chk("mid_f3_valid", fetch_valid, 1);
        chk("mid_f3_data", fetch_data, 0);
        drive(1, 8'd7, 0, 0, 0, 0);
        step();
        chk("mid_f7_data", fetch_data, 0);
        drive(1, 8'h0A, 0, 0, 0, 0);
        step();
        chk("mid_fa_data", fetch_data, 0);
        drive(0, 0, 0, 0, 0, 0);
        step();
        chk("mid_idle_valid", fetch_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
